// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI controller master.
package spi_pkg;

  // Default frame layout: 8-bit command followed by an 8-bit data field.
  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned CMD_BITS     = 8;
  localparam int unsigned CMD_RW_BIT   = 15;
  localparam int unsigned CMD_ADDR_MSB = 14;
  localparam int unsigned CMD_ADDR_LSB = 8;
  localparam int unsigned CMD_ADDR_W   = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider, leading/trailing edge strobes and the
// CPOL idle level whenever the controller is not shifting.
module spi_sclk_gen #(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic run,       // controller outside IDLE
  input  logic shift_en,  // controller in SHIFT
  input  logic cpol,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int unsigned CntW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [CntW-1:0] div_cnt_q;
  logic            sclk_q;

  assign tick  = run && (div_cnt_q == CntW'(DIV_HALF - 1));
  // Leading edge moves SCLK away from its idle level, trailing edge returns it.
  assign lead  = tick && shift_en && (sclk_q == cpol);
  assign trail = tick && shift_en && (sclk_q != cpol);
  assign sclk  = sclk_q;

  // Half-period divider, held at zero while the controller is idle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt_q <= '0;
    end else if (ena) begin
      if (!run || tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
    end
  end

  // SCLK toggles on every tick while shifting, otherwise parks at CPOL.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_q <= 1'b0;
    end else if (ena) begin
      if (shift_en) begin
        if (tick) begin
          sclk_q <= ~sclk_q;
        end
      end else begin
        sclk_q <= cpol;
      end
    end
  end

endmodule

// File: rtl/spi_controller_master.sv
// SPI controller master: turns a start/done request into one write or read
// frame (command byte + data field, MSB first) and captures MISO read data.
module spi_controller_master
  import spi_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DIV_HALF   = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned FrameW   = CMD_BITS + REG_WIDTH;
  localparam int unsigned NumEdges = 2 * FrameW;
  localparam int unsigned EdgeW    = $clog2(NumEdges);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(NumEdges - 1);

  spi_state_e            state_q;
  logic [1:0]            mode_q;
  logic                  rw_q;
  logic [FrameW-1:0]     tx_q;
  logic [REG_WIDTH-1:0]  rx_q;
  logic [EdgeW-1:0]      edge_q;
  logic                  busy_q;
  logic                  done_q;
  logic [REG_WIDTH-1:0]  rdata_q;
  logic                  cs_n_q;
  logic                  mosi_q;

  logic                  tick;
  logic                  lead;
  logic                  trail;
  logic                  accept;
  logic                  cpha;
  logic [FrameW-1:0]     frame_d;

  // A start arriving in the done cycle is dropped, not queued.
  assign accept = start && (state_q == StIdle) && !done_q;
  assign cpha   = mode_q[0];

  // Frame image: rw, zero-extended address, data (zero on reads).
  always_comb begin
    frame_d = {rw, CMD_ADDR_W'(addr), (rw ? wdata : {REG_WIDTH{1'b0}})};
  end

  spi_sclk_gen #(
    .DIV_HALF (DIV_HALF)
  ) u_sclk_gen (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .run      (state_q != StIdle),
    .shift_en (state_q == StShift),
    .cpol     (mode_q[1]),
    .tick     (tick),
    .lead     (lead),
    .trail    (trail),
    .sclk     (spi_clk)
  );

  // Frame FSM with shift registers and registered interface outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      rw_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      edge_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Mode tracks the input while idle so the idle SCLK level follows CPOL.
          mode_q <= mode;
          if (accept) begin
            rw_q    <= rw;
            tx_q    <= frame_d;
            mosi_q  <= frame_d[FrameW-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            edge_q  <= '0;
            state_q <= StSetup;
          end
        end

        StSetup: begin
          if (tick) begin
            state_q <= StShift;
          end
        end

        StShift: begin
          if (lead) begin
            if (cpha) begin
              mosi_q <= tx_q[FrameW-1];
              tx_q   <= tx_q << 1;
            end else begin
              rx_q <= {rx_q[REG_WIDTH-2:0], spi_miso};
            end
          end
          if (trail) begin
            if (cpha) begin
              rx_q <= {rx_q[REG_WIDTH-2:0], spi_miso};
            end else if (edge_q != LastEdge) begin
              // CPHA=0: bit 15 is already on MOSI, so present the next one.
              mosi_q <= tx_q[FrameW-2];
              tx_q   <= tx_q << 1;
            end
          end
          if (tick) begin
            if (edge_q == LastEdge) begin
              edge_q  <= '0;
              state_q <= StHold;
            end else begin
              edge_q <= edge_q + 1'b1;
            end
          end
        end

        StHold: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            state_q <= StGap;
          end
        end

        StGap: begin
          if (tick) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            state_q <= StIdle;
            if (!rw_q) begin
              rdata_q <= rx_q;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule
